// File: rtl/fracnet_psum_pkg.sv
// FracNet partial-sum accumulator: shared widths, state encoding
// and the signed saturating add used by the accumulator.
package fracnet_psum_pkg;

  localparam int PROD_W     = 25;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int FRAC_SHIFT = 8;
  localparam int CNT_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [ACC_W-1:0] sum;
  } sat_sum_t;

  // Add two ACC_W signed values, clamping to the ACC_W range on overflow.
  function automatic sat_sum_t sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    sat_sum_t       r;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    r.sat = (s[ACC_W] != s[ACC_W-1]);
    if (!r.sat)
      r.sum = s[ACC_W-1:0];
    else if (s[ACC_W])
      r.sum = {1'b1, {(ACC_W-1){1'b0}}};
    else
      r.sum = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/fracnet_round_sat.sv
// Round-half-up, arithmetic shift and clip of a wide signed sum
// down to a narrow signed activation.
module fracnet_round_sat #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [IN_W-1:0]  acc,
  output logic [OUT_W-1:0] res,
  output logic             clipped
);

  localparam logic signed [IN_W:0] RND =
    (IN_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [IN_W:0] MAXV =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV =
    {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] wide;
  logic signed [IN_W:0] r;

  // One extra bit keeps the rounding add from wrapping.
  assign wide = $signed({acc[IN_W-1], acc}) + RND;
  assign r    = wide >>> SHIFT;

  // Clamp the shifted value to the output range.
  always_comb begin
    res     = r[OUT_W-1:0];
    clipped = 1'b0;
    if (r > MAXV) begin
      res     = MAXV[OUT_W-1:0];
      clipped = 1'b1;
    end else if (r < MINV) begin
      res     = MINV[OUT_W-1:0];
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/fracnet_psum_accumulator.sv
// Accumulates a group of signed products, then rounds, shifts and
// saturates the sum onto a registered valid/ready output.
module fracnet_psum_accumulator
  import fracnet_psum_pkg::*;
(
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state, nxt;
  logic [ACC_W-1:0] acc, acc_next, prod_ext;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] len_q, len_eff, first_len;
  logic             ovf_q, ovf_next;
  logic             accept, last, clipped;
  logic [OUT_W-1:0] rs_data;
  sat_sum_t         sum;

  assign prod_ready = (state != DONE);
  assign busy       = (state != IDLE);
  assign accept     = prod_valid & prod_ready;
  assign prod_ext   =
    {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign first_len  =
    (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  assign sum        = sat_add(acc, prod_ext);

  // Next accumulator/count values; the first beat restarts the group.
  always_comb begin
    acc_next = sum.sum;
    ovf_next = ovf_q | sum.sat;
    cnt_next = cnt + CNT_W'(1);
    len_eff  = len_q;
    if (state == IDLE) begin
      acc_next = prod_ext;
      ovf_next = 1'b0;
      cnt_next = CNT_W'(1);
      len_eff  = first_len;
    end
    last = accept && (cnt_next == len_eff);
  end

  fracnet_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .acc     (acc_next),
    .res     (rs_data),
    .clipped (clipped)
  );

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = last ? DONE : ACC;
      ACC:  if (last) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Accumulator, counters and the registered result.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_next;
        cnt   <= cnt_next;
        ovf_q <= ovf_next;
        if (state == IDLE)
          len_q <= first_len;
      end
      if (last) begin
        out_valid <= 1'b1;
        out_data  <= rs_data;
        out_ovf   <= ovf_next | clipped;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
